ptb_checker: RTL and testbench
==============================

// Module: ptb_checker
// PURPOSE
//  Receive-side checker for the 43-bit pseudo-random test-bit (PTB) stream from the lfsr43 generator.
//  - Runs a local replica LFSR with the same seed, taps and output parity in lockstep from the shared reset.
//  - On every i_ptb_valid, compares i_ptb with the replica bit, then counts checked bits and mismatches.
//  - Assembles received bits into words and flags failure when the error threshold is reached.
//  - Sits on the scaler test path, wired directly (zero pipeline stages) to the generator outputs.
// PARAMETERS
//  SEED        43'h1ABCDE12345  replica reset state; must equal the generator seed
//  WORD_W      8                received bits per assembled word (>=2)
//  CNT_W       16               width of the bit and error counters (saturating)
//  ERR_THRESH  4                error count at which o_fail sets (1..2**CNT_W-1)
// PORTS
//  clk           in   1       single clock, same clock as the generator
//  rst_n         in   1       asynchronous active-low reset, shared with the generator
//  i_ptb         in   1       received test bit
//  i_ptb_valid   in   1       one-cycle strobe marking i_ptb as a sample
//  i_clear       in   1       synchronous clear of counters, fail flag and word index
//  o_word        out  WORD_W  last assembled word, LSB = first received bit
//  o_word_valid  out  1       one-cycle pulse when o_word updates
//  o_bit_count   out  CNT_W   samples checked since reset or clear, saturating
//  o_err_count   out  CNT_W   mismatching samples, saturating at all-ones
//  o_locked      out  1       high in state CHECK
//  o_fail        out  1       sticky; high in state FAIL
// BEHAVIOUR
//  - Reset: every output is 0, replica = SEED, exp_bit = 0, word index = 0, state = WAIT.
//  - Replica LFSR advances every cycle, independent of valid and clear:
//      fb    = ~(s[42]^s[41]^s[37]^s[36])
//      s     <= {s[41:0], fb}
//      exp_bit <= ^s[27:21]   (old s)
//    exp_bit is therefore cycle-aligned with the generator's registered o_ptb.
//  - A sample is a cycle with i_ptb_valid=1 and i_clear=0.
//  - Sample effects, all applied at the same edge:
//      bit_count += 1
//      if i_ptb != exp_bit: err_count += 1
//      shift reg <= {i_ptb, sr[WORD_W-1:1]}; index += 1
//  - Word completion: when index reaches WORD_W, the completed shift value goes to o_word,
//    o_word_valid pulses for 1 cycle, index returns to 0. Latency: last bit in to o_word_valid = 1 clk.
//  - Both counters saturate at 2**CNT_W-1 and never wrap.
//  - FSM:
//      WAIT  -> CHECK on the first sample
//      CHECK -> FAIL when the updated err_count >= ERR_THRESH (o_fail rises at that same edge)
//      FAIL  holds until i_clear or reset; samples are still counted in FAIL
//  - i_clear:
//      zeroes bit_count, err_count, index and o_fail; FAIL -> CHECK; WAIT stays WAIT
//      does not touch the replica (alignment is kept) and does not change o_word
//      clear wins over a simultaneous valid: that sample is discarded and o_word_valid stays 0
//  - Reset mid-operation: everything returns to reset values immediately (async).
//    The generator must be reset by the same rst_n or alignment is lost.
// STRUCTURE
//  - ptb_pkg holds:
//      PTB_SEED
//      tap indices 42/41/37/36
//      parity slice bounds 27:21
//      state enum {WAIT, CHECK, FAIL}
//  - Sub-module ptb_lfsr_ref (43-bit replica plus registered exp_bit), reusable by the generator.
//  - Counters, word assembler and FSM live in ptb_checker.
// TESTING
//  - Direct hookup to lfsr43, 3000 clks -> err_count=0, o_locked=1, o_fail=0,
//    bit_count = number of generator valid pulses (93).
//  - Invert i_ptb on valid samples 3 and 5 -> err_count=2, o_fail=0; invert samples 7 and 9 -> err_count=4,
//    o_fail rises on the edge of sample 9, o_locked=0.
//  - i_clear while in FAIL, then a clean stream for 40 samples -> bit_count=40, err_count=0, o_fail=0, o_locked=1.
//  - WORD_W=8 -> o_word_valid exactly once per 8 samples, o_word = reference model bits LSB-first;
//    i_clear together with sample 4 -> no word until 8 further samples.
//  - CNT_W=4, all samples inverted for 20 samples -> err_count holds at 15, bit_count holds at 15, o_fail=1.
//  - Pulse rst_n low for 2 clks mid-word -> all outputs 0 and state WAIT during reset;
//    after release, 500 clean clks -> err_count=0.

Source files
------------

// File: rtl/ptb_pkg.sv
// ============================================================================
// ptb_pkg : shared constants, state encoding and LFSR helper for the PTB path
// Revision: 1.0
// ============================================================================
`default_nettype none

package ptb_pkg;

  localparam logic [42:0] PTB_SEED = 43'h1ABCDE12345;

  localparam int TAP_A = 42;
  localparam int TAP_B = 41;
  localparam int TAP_C = 37;
  localparam int TAP_D = 36;

  localparam int PAR_HI = 27;
  localparam int PAR_LO = 21;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_CHECK = 2'd1,
    ST_FAIL  = 2'd2
  } ptb_state_e;

  function automatic logic lfsr_fb(input logic [42:0] s);
    return ~(s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ptb_lfsr_ref.sv
// ============================================================================
// ptb_lfsr_ref : 43-bit PTB LFSR with registered parity output bit
// Revision: 1.0
// ============================================================================
`default_nettype none

module ptb_lfsr_ref
  import ptb_pkg::*;
#(
  parameter logic [42:0] SEED = PTB_SEED
) (
  input  logic clk,
  input  logic rst_n,
  output logic exp_bit_o
);

  logic [42:0] state_q;
  logic        exp_bit_q;

  // Free-running: advances every cycle so it stays aligned with the generator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SEED;
      exp_bit_q <= 1'b0;
    end else begin
      state_q   <= {state_q[41:0], lfsr_fb(state_q)};
      exp_bit_q <= ^state_q[PAR_HI:PAR_LO];
    end
  end

  assign exp_bit_o = exp_bit_q;

endmodule

`default_nettype wire

// File: rtl/ptb_checker.sv
// ============================================================================
// ptb_checker : PTB stream checker - replica compare, counters, words, FSM
// Revision: 1.0
// ============================================================================
`default_nettype none

module ptb_checker
  import ptb_pkg::*;
#(
  parameter logic [42:0] SEED       = PTB_SEED,
  parameter int          WORD_W     = 8,
  parameter int          CNT_W      = 16,
  parameter int          ERR_THRESH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_ptb,
  input  logic              i_ptb_valid,
  input  logic              i_clear,
  output logic [WORD_W-1:0] o_word,
  output logic              o_word_valid,
  output logic [CNT_W-1:0]  o_bit_count,
  output logic [CNT_W-1:0]  o_err_count,
  output logic              o_locked,
  output logic              o_fail
);

  localparam int                IDX_W    = $clog2(WORD_W);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  THRESH   = CNT_W'(ERR_THRESH);

  logic exp_bit;

  ptb_lfsr_ref #(.SEED(SEED)) u_ref (
    .clk       (clk),
    .rst_n     (rst_n),
    .exp_bit_o (exp_bit)
  );

  ptb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [WORD_W-1:0] sr_q, sr_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              wv_q, wv_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_WAIT;
      bit_cnt_q <= '0;
      err_cnt_q <= '0;
      sr_q      <= '0;
      word_q    <= '0;
      idx_q     <= '0;
      wv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      err_cnt_q <= err_cnt_d;
      sr_q      <= sr_d;
      word_q    <= word_d;
      idx_q     <= idx_d;
      wv_q      <= wv_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    err_cnt_d = err_cnt_q;
    sr_d      = sr_q;
    word_d    = word_q;
    idx_d     = idx_q;
    wv_d      = 1'b0;
    // Clear outranks a coincident valid: that sample is dropped entirely.
    if (i_clear) begin
      bit_cnt_d = '0;
      err_cnt_d = '0;
      idx_d     = '0;
      if (state_q == ST_FAIL) state_d = ST_CHECK;
    end else if (i_ptb_valid) begin
      if (bit_cnt_q != CNT_MAX) bit_cnt_d = bit_cnt_q + CNT_W'(1);
      if ((i_ptb != exp_bit) && (err_cnt_q != CNT_MAX)) err_cnt_d = err_cnt_q + CNT_W'(1);
      sr_d = {i_ptb, sr_q[WORD_W-1:1]};
      if (idx_q == IDX_LAST) begin
        word_d = sr_d;
        wv_d   = 1'b1;
        idx_d  = '0;
      end else begin
        idx_d  = idx_q + IDX_W'(1);
      end
      if (state_q != ST_FAIL) state_d = (err_cnt_d >= THRESH) ? ST_FAIL : ST_CHECK;
    end
  end

  assign o_word       = word_q;
  assign o_word_valid = wv_q;
  assign o_bit_count  = bit_cnt_q;
  assign o_err_count  = err_cnt_q;
  assign o_locked     = (state_q == ST_CHECK);
  assign o_fail       = (state_q == ST_FAIL);

endmodule

`default_nettype wire

// File: tb/tb_ptb_checker.sv
// ============================================================================
// tb_ptb_checker : randomized self-checking bench for ptb_checker (two configs)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ptb_checker;

  localparam int SEQ_N = 8192;

  logic       clk;
  logic       rst_n;
  logic       i_ptb;
  logic       i_ptb_valid;
  logic       i_clear;

  logic [7:0]  o_word_a, o_word_b;
  logic        o_word_valid_a, o_word_valid_b;
  logic [15:0] o_bit_count_a, o_err_count_a;
  logic [3:0]  o_bit_count_b, o_err_count_b;
  logic        o_locked_a, o_locked_b, o_fail_a, o_fail_b;

  ptb_checker u_dut_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_ptb        (i_ptb),
    .i_ptb_valid  (i_ptb_valid),
    .i_clear      (i_clear),
    .o_word       (o_word_a),
    .o_word_valid (o_word_valid_a),
    .o_bit_count  (o_bit_count_a),
    .o_err_count  (o_err_count_a),
    .o_locked     (o_locked_a),
    .o_fail       (o_fail_a)
  );

  ptb_checker #(.CNT_W(4)) u_dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_ptb        (i_ptb),
    .i_ptb_valid  (i_ptb_valid),
    .i_clear      (i_clear),
    .o_word       (o_word_b),
    .o_word_valid (o_word_valid_b),
    .o_bit_count  (o_bit_count_b),
    .o_err_count  (o_err_count_b),
    .o_locked     (o_locked_b),
    .o_fail       (o_fail_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: the generator's bit as seen before posedge number c+1 after reset.
  bit exp_seq [SEQ_N];
  int cyc;

  int       mdl_bit  [2];
  int       mdl_err  [2];
  bit       mdl_lock [2];
  bit       mdl_fail [2];
  int       mdl_max  [2];
  bit       wq [$];
  bit [7:0] mdl_word;
  bit       mdl_wv;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mdl_bit[k] = 0; mdl_err[k] = 0; mdl_lock[k] = 0; mdl_fail[k] = 0;
    end
    wq.delete();
    mdl_word = '0;
    mdl_wv   = 0;
    cyc      = 0;
  endtask

  task automatic model_update(input bit v, input bit b, input bit clr, input bit expb);
    mdl_wv = 0;
    if (clr) begin
      for (int k = 0; k < 2; k++) begin
        mdl_bit[k] = 0; mdl_err[k] = 0;
        if (mdl_fail[k]) begin mdl_fail[k] = 0; mdl_lock[k] = 1; end
      end
      wq.delete();
    end else if (v) begin
      for (int k = 0; k < 2; k++) begin
        if (mdl_bit[k] < mdl_max[k]) mdl_bit[k]++;
        if (b != expb && mdl_err[k] < mdl_max[k]) mdl_err[k]++;
        if (!mdl_fail[k]) mdl_lock[k] = 1;
        if (!mdl_fail[k] && mdl_err[k] >= 4) begin mdl_fail[k] = 1; mdl_lock[k] = 0; end
      end
      wq.push_back(b);
      if (wq.size() == 8) begin
        for (int i = 0; i < 8; i++) mdl_word[i] = wq[i];
        wq.delete();
        mdl_wv = 1;
      end
    end
  endtask

  task automatic check_all();
    chk("a_word",  {24'd0, o_word_a},        {24'd0, mdl_word});
    chk("a_wv",    {31'd0, o_word_valid_a},  {31'd0, mdl_wv});
    chk("a_bits",  {16'd0, o_bit_count_a},   mdl_bit[0]);
    chk("a_errs",  {16'd0, o_err_count_a},   mdl_err[0]);
    chk("a_lock",  {31'd0, o_locked_a},      {31'd0, mdl_lock[0]});
    chk("a_fail",  {31'd0, o_fail_a},        {31'd0, mdl_fail[0]});
    chk("b_word",  {24'd0, o_word_b},        {24'd0, mdl_word});
    chk("b_wv",    {31'd0, o_word_valid_b},  {31'd0, mdl_wv});
    chk("b_bits",  {28'd0, o_bit_count_b},   mdl_bit[1]);
    chk("b_errs",  {28'd0, o_err_count_b},   mdl_err[1]);
    chk("b_lock",  {31'd0, o_locked_b},      {31'd0, mdl_lock[1]});
    chk("b_fail",  {31'd0, o_fail_b},        {31'd0, mdl_fail[1]});
  endtask

  // Called at a negedge: drive one cycle, advance the model, check after the edge.
  task automatic step(input bit v, input bit inv, input bit clr);
    bit b;
    b           = exp_seq[cyc] ^ inv;
    i_ptb       = b;
    i_ptb_valid = v;
    i_clear     = clr;
    model_update(v, b, clr, exp_seq[cyc]);
    cyc++;
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset(input int n);
    rst_n       = 1'b0;
    i_ptb       = 1'b0;
    i_ptb_valid = 1'b0;
    i_clear     = 1'b0;
    model_reset();
    #1;
    check_all();
    repeat (n) begin
      @(negedge clk);
      check_all();
    end
    rst_n = 1'b1;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 3)) step(0, 0, 0);
  endtask

  initial begin
    bit [42:0] s;
    int        n_valid;

    s = 43'h1ABCDE12345;
    exp_seq[0] = 0;
    for (int c = 1; c < SEQ_N; c++) begin
      exp_seq[c] = ^s[27:21];
      s = {s[41:0], ~(s[42] ^ s[41] ^ s[37] ^ s[36])};
    end
    mdl_max[0] = 65535;
    mdl_max[1] = 15;

    do_reset(3);
    chk("rst_bits", {16'd0, o_bit_count_a}, 0);
    chk("rst_word", {24'd0, o_word_a}, 0);

    // Clean stream with sparse random strobes.
    n_valid = 0;
    for (int i = 0; i < 3000; i++) begin
      bit v;
      v = ($urandom_range(0, 31) == 0);
      if (v) n_valid++;
      step(v, 0, 0);
    end
    chk("clean_bits", {16'd0, o_bit_count_a}, n_valid);
    chk("clean_errs", {16'd0, o_err_count_a}, 0);
    chk("clean_lock", {31'd0, o_locked_a}, 1);
    chk("clean_fail", {31'd0, o_fail_a}, 0);

    // Inject errors on samples 3, 5, 7 and 9.
    step(0, 0, 1);
    for (int n = 1; n <= 9; n++) begin
      gap();
      step(1, (n == 3 || n == 5 || n == 7 || n == 9), 0);
      if (n == 5) begin
        chk("inj5_errs", {16'd0, o_err_count_a}, 2);
        chk("inj5_fail", {31'd0, o_fail_a}, 0);
      end
      if (n == 8) chk("inj8_fail", {31'd0, o_fail_a}, 0);
    end
    chk("inj9_errs", {16'd0, o_err_count_a}, 4);
    chk("inj9_fail", {31'd0, o_fail_a}, 1);
    chk("inj9_lock", {31'd0, o_locked_a}, 0);

    // Clear from FAIL, then 40 clean samples.
    step(0, 0, 1);
    chk("clr_fail", {31'd0, o_fail_a}, 0);
    chk("clr_lock", {31'd0, o_locked_a}, 1);
    for (int n = 0; n < 40; n++) begin
      gap();
      step(1, 0, 0);
    end
    chk("c40_bits", {16'd0, o_bit_count_a}, 40);
    chk("c40_errs", {16'd0, o_err_count_a}, 0);
    chk("c40_lock", {31'd0, o_locked_a}, 1);

    // Clear coincident with sample 4 restarts word assembly.
    step(0, 0, 1);
    for (int n = 0; n < 3; n++) step(1, 0, 0);
    step(1, 0, 1);
    chk("cs4_wv", {31'd0, o_word_valid_a}, 0);
    for (int n = 1; n <= 8; n++) begin
      gap();
      step(1, 0, 0);
      chk("cs4_word_pulse", {31'd0, o_word_valid_a}, (n == 8) ? 1 : 0);
    end

    // Saturation: every sample wrong for 20 samples.
    step(0, 0, 1);
    for (int n = 0; n < 20; n++) step(1, 1, 0);
    chk("sat_b_errs", {28'd0, o_err_count_b}, 15);
    chk("sat_b_bits", {28'd0, o_bit_count_b}, 15);
    chk("sat_b_fail", {31'd0, o_fail_b}, 1);
    chk("sat_a_errs", {16'd0, o_err_count_a}, 20);
    chk("sat_a_bits", {16'd0, o_bit_count_a}, 20);

    // Reset in the middle of a word, then a clean run.
    step(0, 0, 1);
    for (int n = 0; n < 5; n++) step(1, 0, 0);
    do_reset(2);
    chk("mid_rst_lock", {31'd0, o_locked_a}, 0);
    chk("mid_rst_errs", {16'd0, o_err_count_a}, 0);
    for (int i = 0; i < 500; i++) step($urandom_range(0, 3) == 0, 0, 0);
    chk("post_rst_errs", {16'd0, o_err_count_a}, 0);
    chk("post_rst_lock", {31'd0, o_locked_a}, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
